// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared sizes, state type and helpers for the interpolation chain sequencer
package interp_pkg;

  localparam int unsigned DW     = 24;
  localparam int unsigned NSTAGE = 3;
  localparam int unsigned CW     = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  // |a - b| widened by one bit so a small b minus a large a cannot wrap.
  function automatic logic [CW:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[CW] ? (~d + (CW+1)'(1)) : d;
  endfunction

endpackage

// File: rtl/interp_rate_divider.sv
// rtl/interp_rate_divider.sv - reloadable down-counter emitting a one-cycle strobe per reload
module interp_rate_divider
  import interp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] reload_i,
  output logic          strobe_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;
  logic          fire;

  // A forced load landing on a natural reload is one event, so one strobe.
  always_comb begin
    fire     = load_i || (cnt_q == '0);
    cnt_d    = fire ? reload_i : (cnt_q - CW'(1));
    strobe_d = fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/interp_chain_sequencer.sv
// rtl/interp_chain_sequencer.sv - locks to the PCM sample rate and strobes the 2x interpolator stages
module interp_chain_sequencer
  import interp_pkg::*;
#(
  parameter logic [CW-1:0] NOM_PERIOD = CW'(512),
  parameter logic [CW-1:0] TOL        = CW'(4),
  parameter int unsigned   LOCK_N     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     pcm_in,
  input  logic              pcm_in_vld,
  input  logic              err_clr,
  output logic [DW-1:0]     pcm_out,
  output logic [NSTAGE-1:0] en_stage,
  output logic              mute,
  output logic              locked,
  output logic              err_unlock,
  output logic [CW-1:0]     period
);

  localparam int unsigned MW = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  seq_state_e    state_q, state_d;
  logic [CW-1:0] meas_cnt_q, meas_cnt_d;
  logic [CW-1:0] ref_q, ref_d;
  logic          has_ref_q, has_ref_d;
  logic [MW-1:0] match_q, match_d;
  logic [MW-1:0] match_next;
  logic [CW-1:0] period_q, period_d;
  logic          err_q, err_d;
  logic [DW-1:0] pcm_q, pcm_d;

  logic          meas_sat;
  logic [CW-1:0] m_val;
  logic          m_shape_ok;
  logic          m_ref_ok;
  logic          m_run_ok;
  logic [CW:0]   elapsed;
  logic [CW:0]   run_limit;
  logic          miss;
  logic          unlock;
  logic          load;

  // M is the number of clk cycles from one pcm_in_vld to the next.
  always_comb begin
    meas_sat   = (meas_cnt_q == CNT_MAX);
    m_val      = meas_sat ? CNT_MAX : (meas_cnt_q + CW'(1));
    m_shape_ok = (m_val[NSTAGE-1:0] == '0) && (m_val >= CW'(2 ** (NSTAGE + 1)));
    m_ref_ok   = !has_ref_q || (abs_diff(m_val, ref_q) <= {1'b0, TOL});
    m_run_ok   = (abs_diff(m_val, period_q) <= {1'b0, TOL});
    elapsed    = {1'b0, meas_cnt_q} + (CW+1)'(1);
    run_limit  = {1'b0, period_q} + {1'b0, TOL};
    miss       = (elapsed > run_limit);
  end

  always_comb begin
    state_d    = state_q;
    meas_cnt_d = pcm_in_vld ? '0 : (meas_sat ? meas_cnt_q : (meas_cnt_q + CW'(1)));
    ref_d      = ref_q;
    has_ref_d  = has_ref_q;
    match_d    = match_q;
    match_next = match_q + MW'(1);
    period_d   = period_q;
    unlock     = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pcm_in_vld) begin
          state_d   = ACQ;
          has_ref_d = 1'b0;
          match_d   = '0;
        end
      end

      ACQ: begin
        if (pcm_in_vld) begin
          if (m_shape_ok && m_ref_ok) begin
            if (!has_ref_q) begin
              ref_d = m_val;
            end
            has_ref_d = 1'b1;
            match_d   = match_next;
            if (match_next == MW'(LOCK_N)) begin
              state_d  = RUN;
              period_d = has_ref_q ? ref_q : m_val;
              match_d  = '0;
              load     = 1'b1;
            end
          end else begin
            match_d   = '0;
            ref_d     = m_val;
            has_ref_d = 1'b1;
          end
        end else if (meas_sat) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (pcm_in_vld) begin
          if (m_run_ok) begin
            load = 1'b1;
          end else begin
            unlock = 1'b1;
          end
        end else if (miss) begin
          unlock = 1'b1;
        end
        // Realign all stages on unlock so the free-run strobes stay nested.
        if (unlock) begin
          state_d   = ACQ;
          has_ref_d = 1'b0;
          match_d   = '0;
          period_d  = NOM_PERIOD;
          load      = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        period_d = NOM_PERIOD;
      end
    endcase

    err_d = unlock ? 1'b1 : (err_clr ? 1'b0 : err_q);

    if (state_d != RUN) begin
      pcm_d = '0;
    end else if (pcm_in_vld) begin
      pcm_d = pcm_in;
    end else begin
      pcm_d = pcm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      meas_cnt_q <= '0;
      ref_q      <= '0;
      has_ref_q  <= 1'b0;
      match_q    <= '0;
      period_q   <= NOM_PERIOD;
      err_q      <= 1'b0;
      pcm_q      <= '0;
    end else begin
      state_q    <= state_d;
      meas_cnt_q <= meas_cnt_d;
      ref_q      <= ref_d;
      has_ref_q  <= has_ref_d;
      match_q    <= match_d;
      period_q   <= period_d;
      err_q      <= err_d;
      pcm_q      <= pcm_d;
    end
  end

  // Stage k reloads every (P >> (k+1)) cycles, P being the period about to be in force.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [CW-1:0] reload_k;
    assign reload_k = (period_d >> (k + 1)) - CW'(1);

    interp_rate_divider u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load),
      .reload_i (reload_k),
      .strobe_o (en_stage[k])
    );
  end

  assign pcm_out    = pcm_q;
  assign mute       = (state_q != RUN);
  assign locked     = (state_q == RUN);
  assign err_unlock = err_q;
  assign period     = period_q;

endmodule

// File: tb/tb_interp_chain_sequencer.sv
// tb/tb_interp_chain_sequencer.sv - scoreboard bench for interp_chain_sequencer
module tb_interp_chain_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] pcm_in;
  logic        pcm_in_vld;
  logic        err_clr;
  logic [23:0] pcm_out;
  logic [2:0]  en_stage;
  logic        mute;
  logic        locked;
  logic        err_unlock;
  logic [11:0] period;

  interp_chain_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcm_in     (pcm_in),
    .pcm_in_vld (pcm_in_vld),
    .err_clr    (err_clr),
    .pcm_out    (pcm_out),
    .en_stage   (en_stage),
    .mute       (mute),
    .locked     (locked),
    .err_unlock (err_unlock),
    .period     (period)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] pcm;
    logic        lk;
    bit          chk_en;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   s0 = 0, s1 = 0, s2 = 0;
  int   dbl = 0, viol = 0;
  logic en0_prev = 1'b0;
  int   b0, b1, b2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Outputs expected one cycle after each pcm_in_vld.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_e = sb_q.pop_front();
      chk("sb_pcm_out", 32'(pcm_out), 32'(sb_e.pcm));
      chk("sb_locked", 32'(locked), 32'(sb_e.lk));
      chk("sb_mute", 32'(mute), 32'(!sb_e.lk));
      if (sb_e.chk_en) chk("sb_en_stage", 32'(en_stage), 32'h7);
    end
  end

  always @(negedge clk) begin
    if (en_stage[0] === 1'b1) s0++;
    if (en_stage[1] === 1'b1) s1++;
    if (en_stage[2] === 1'b1) s2++;
    if (en_stage[0] === 1'b1 && en0_prev === 1'b1) dbl++;
    if (en_stage[0] === 1'b1 && en_stage[1] !== 1'b1) viol++;
    if (en_stage[1] === 1'b1 && en_stage[2] !== 1'b1) viol++;
    en0_prev = en_stage[0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d, input logic lk, input bit ce);
    sb_q.push_back('{cyc + 1, lk ? d : 24'h0, lk, ce});
    pcm_in     = d;
    pcm_in_vld = 1'b1;
    tick(1);
    pcm_in_vld = 1'b0;
  endtask

  task automatic snap();
    b0 = s0; b1 = s1; b2 = s2;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_en0"}, 32'(s0 - b0), 32'd2);
    chk({tag, "_en1"}, 32'(s1 - b1), 32'd4);
    chk({tag, "_en2"}, 32'(s2 - b2), 32'd8);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pcm_out"}, 32'(pcm_out), 32'h0);
    chk({tag, "_en_stage"}, 32'(en_stage), 32'h0);
    chk({tag, "_mute"}, 32'(mute), 32'h1);
    chk({tag, "_locked"}, 32'(locked), 32'h0);
    chk({tag, "_err"}, 32'(err_unlock), 32'h0);
    chk({tag, "_period"}, 32'(period), 32'd512);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 100000", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pcm_in = '0; pcm_in_vld = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    tick(1);
    rst_n = 1'b1;
    tick(5);

    // Lock at 512, then one full locked period of strobes.
    send(24'h000111, 1'b0, 1'b0); tick(511);
    send(24'h000222, 1'b0, 1'b0); tick(511);
    send(24'h000333, 1'b1, 1'b1);
    chk("period_locked", 32'(period), 32'd512);
    snap();
    tick(511);
    send(24'h7FFFFF, 1'b1, 1'b1);
    chk_counts("rate512");

    // Full-scale sample is held between input strobes.
    tick(300);
    chk("pcm_hold", 32'(pcm_out), 32'h7FFFFF);
    tick(211);

    // Jittered input: 514 then 509 stays locked and resyncs.
    send(24'h123456, 1'b1, 1'b1); tick(513);
    send(24'h234567, 1'b1, 1'b1); tick(508);
    send(24'h345678, 1'b1, 1'b1); tick(511);
    chk("jitter_locked", 32'(locked), 32'h1);
    chk("no_double_pulse", 32'(dbl), 32'h0);

    // One-cycle reset mid-RUN, then relock after three strobes.
    tick(200);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("midrun_reset");
    tick(3);
    send(24'h0A0001, 1'b0, 1'b0); tick(511);
    send(24'h0A0002, 1'b0, 1'b0); tick(511);
    send(24'h0A0003, 1'b1, 1'b1); tick(511);

    // Missing sample: unlock detected 517 cycles after the last strobe; err_clr loses to the set.
    send(24'h0ABCDE, 1'b1, 1'b1);
    tick(516);
    err_clr = 1'b1;
    @(negedge clk);
    chk("miss_still_locked", 32'(locked), 32'h1);
    tick(1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("miss_locked", 32'(locked), 32'h0);
    chk("miss_mute", 32'(mute), 32'h1);
    chk("miss_err_set_wins", 32'(err_unlock), 32'h1);
    chk("miss_pcm_out", 32'(pcm_out), 32'h0);
    chk("miss_period", 32'(period), 32'd512);
    tick(1);
    snap();
    tick(512);
    chk_counts("freerun");

    // Period 500 is not a multiple of 8: never locks.
    tick(3);
    for (int i = 0; i < 5; i++) begin
      send(24'h000500 + 24'(i), 1'b0, 1'b0);
      tick(499);
    end
    chk("p500_mute", 32'(mute), 32'h1);
    chk("err_sticky", 32'(err_unlock), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err_unlock), 32'h0);

    chk("stage_nesting", 32'(viol), 32'h0);
    tick(2);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
